// File: rtl/enemy_bullet_ctl.sv
// rtl/enemy_bullet_ctl.sv - enemy bullet spawn/cooldown/motion controller
// One bullet at a time: cooldown in WAIT, spawn below the enemy, fall once per frame tick.
module enemy_bullet_ctl #(
    parameter int COOLDOWN  = 3,
    parameter int SPEED     = 8,
    parameter int SPAWN_OFF = 20,
    parameter int Y_SHIP    = 680,
    parameter int Y_MAX     = 768
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [10:0] enemy_X,
    input  logic [10:0] enemy_Y,
    input  logic        enemy_alive,
    input  logic        ship_hit,
    output logic [10:0] enBullet_X,
    output logic [10:0] enBullet_Y,
    output logic        bullet_active,
    output logic        fire_pulse
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FLY  = 2'd2
    } state_t;

    localparam logic [7:0]  COOLDOWN_C  = 8'(COOLDOWN);
    localparam logic [11:0] SPEED_C     = 12'(SPEED);
    localparam logic [11:0] SPAWN_OFF_C = 12'(SPAWN_OFF);
    localparam logic [11:0] Y_SHIP_C    = 12'(Y_SHIP);
    localparam logic [11:0] Y_MAX_C     = 12'(Y_MAX);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        active_q, active_d;
    logic        fire_q, fire_d;

    // 12-bit sums so that an overflow past 2047 still reads as off-screen
    logic [11:0] spawn_y;
    logic [11:0] next_y;

    assign spawn_y = {1'b0, enemy_Y} + SPAWN_OFF_C;
    assign next_y  = {1'b0, y_q} + SPEED_C;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        active_d = active_q;
        fire_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enemy_alive && !ship_hit) begin
                    cnt_d   = COOLDOWN_C;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!enemy_alive || ship_hit) begin
                    state_d = IDLE;
                end else if (frame_tick) begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else if (spawn_y >= Y_MAX_C) begin
                        state_d = IDLE;
                    end else begin
                        x_d      = enemy_X;
                        y_d      = spawn_y[10:0];
                        active_d = 1'b1;
                        fire_d   = 1'b1;
                        state_d  = FLY;
                    end
                end
            end
            FLY: begin
                if (ship_hit) begin
                    x_d      = 11'd0;
                    y_d      = 11'd0;
                    active_d = 1'b0;
                    state_d  = IDLE;
                end else if (frame_tick) begin
                    // Land exactly on the ship row so the equality detector cannot miss it
                    if (({1'b0, y_q} < Y_SHIP_C) && (next_y > Y_SHIP_C)) begin
                        y_d = Y_SHIP_C[10:0];
                    end else if (next_y >= Y_MAX_C) begin
                        x_d      = 11'd0;
                        y_d      = 11'd0;
                        active_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        y_d = next_y[10:0];
                    end
                end
            end
            default: begin
                x_d      = 11'd0;
                y_d      = 11'd0;
                active_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            x_q      <= 11'd0;
            y_q      <= 11'd0;
            active_q <= 1'b0;
            fire_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            active_q <= active_d;
            fire_q   <= fire_d;
        end
    end

    assign enBullet_X    = x_q;
    assign enBullet_Y    = y_q;
    assign bullet_active = active_q;
    assign fire_pulse    = fire_q;

endmodule

// File: tb/tb_enemy_bullet_ctl.sv
// tb/tb_enemy_bullet_ctl.sv - self-checking bench for enemy_bullet_ctl
module tb_enemy_bullet_ctl;

    localparam int COOLDOWN  = 3;
    localparam int SPEED     = 8;
    localparam int SPAWN_OFF = 20;
    localparam int Y_SHIP    = 680;
    localparam int Y_MAX     = 768;

    logic        pclk = 1'b0;
    logic        rst, frame_tick, enemy_alive, ship_hit;
    logic [10:0] enemy_X, enemy_Y;
    logic [10:0] enBullet_X, enBullet_Y;
    logic        bullet_active, fire_pulse;

    int n_checks = 0;
    int n_errors = 0;

    enemy_bullet_ctl dut (
        .pclk         (pclk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .enemy_X      (enemy_X),
        .enemy_Y      (enemy_Y),
        .enemy_alive  (enemy_alive),
        .ship_hit     (ship_hit),
        .enBullet_X   (enBullet_X),
        .enBullet_Y   (enBullet_Y),
        .bullet_active(bullet_active),
        .fire_pulse   (fire_pulse)
    );

    always #5 pclk = ~pclk;

    // Reference model: "armed" = waiting, ticks_left = ticks still to see before firing
    bit m_flying, m_armed;
    int m_ticks_left, m_x, m_y;
    bit m_fire;

    task automatic model_update();
        int sy, ny;
        m_fire = 0;
        if (rst) begin
            m_flying = 0; m_armed = 0; m_x = 0; m_y = 0; m_ticks_left = 0;
        end else if (m_flying) begin
            if (ship_hit) begin
                m_flying = 0; m_x = 0; m_y = 0;
            end else if (frame_tick) begin
                ny = m_y + SPEED;
                if (m_y < Y_SHIP && ny > Y_SHIP) m_y = Y_SHIP;
                else if (ny >= Y_MAX) begin m_flying = 0; m_x = 0; m_y = 0; end
                else m_y = ny;
            end
        end else if (m_armed) begin
            if (!enemy_alive || ship_hit) m_armed = 0;
            else if (frame_tick) begin
                m_ticks_left--;
                if (m_ticks_left == 0) begin
                    m_armed = 0;
                    sy = int'(enemy_Y) + SPAWN_OFF;
                    if (sy < Y_MAX) begin
                        m_flying = 1; m_fire = 1; m_x = int'(enemy_X); m_y = sy;
                    end
                end
            end
        end else if (enemy_alive && !ship_hit) begin
            m_armed = 1; m_ticks_left = COOLDOWN + 1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit t, input bit a, input bit h,
                        input int ex, input int ey);
        rst = r; frame_tick = t; enemy_alive = a; ship_hit = h;
        enemy_X = 11'(ex); enemy_Y = 11'(ey);
        @(posedge pclk);
        model_update();
        #1;
        if (enBullet_X != 11'(m_x) || enBullet_Y != 11'(m_y) ||
            bullet_active != m_flying || fire_pulse != m_fire) begin
            chk("model_x", int'(enBullet_X), m_x);
            chk("model_y", int'(enBullet_Y), m_y);
            chk("model_act", int'(bullet_active), int'(m_flying));
            chk("model_fire", int'(fire_pulse), int'(m_fire));
        end else begin
            n_checks++;
        end
    endtask

    // Reset, arm, then COOLDOWN+1 ticks; returns with the bullet just fired
    task automatic fire_at(input int ex, input int ey);
        step(1, 0, 0, 0, ex, ey);
        step(0, 0, 1, 0, ex, ey);
        for (int i = 0; i < COOLDOWN; i++) begin
            step(0, 1, 1, 0, ex, ey);
            chk("no_early_fire", int'(fire_pulse), 0);
        end
        step(0, 1, 1, 0, ex, ey);
        chk("fire_pulse", int'(fire_pulse), 1);
        chk("fire_y", int'(enBullet_Y), ey + SPAWN_OFF);
    endtask

    typedef struct {
        bit r, t, a, h;
        int ex, ey;
        int e_act, e_fire, e_x, e_y;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int fires, k;
        rst = 1; frame_tick = 0; enemy_alive = 0; ship_hit = 0;
        enemy_X = '0; enemy_Y = '0;

        //        r  t  a  h   ex   ey  act fire   x    y
        tbl[0]  = '{1, 0, 0, 0, 400, 100, 0, 0,   0,   0};
        tbl[1]  = '{0, 0, 1, 0, 400, 100, 0, 0,   0,   0};
        tbl[2]  = '{0, 1, 1, 0, 400, 100, 0, 0,   0,   0};
        tbl[3]  = '{0, 1, 1, 0, 400, 100, 0, 0,   0,   0};
        tbl[4]  = '{0, 1, 1, 0, 400, 100, 0, 0,   0,   0};
        tbl[5]  = '{0, 1, 1, 0, 400, 100, 1, 1, 400, 120};
        tbl[6]  = '{0, 0, 1, 0, 500, 300, 1, 0, 400, 120};
        tbl[7]  = '{0, 1, 0, 0, 500, 300, 1, 0, 400, 128};
        tbl[8]  = '{0, 1, 1, 0, 400, 100, 1, 0, 400, 136};
        tbl[9]  = '{0, 1, 1, 1, 400, 100, 0, 0,   0,   0};
        tbl[10] = '{0, 1, 1, 1, 400, 100, 0, 0,   0,   0};
        tbl[11] = '{0, 0, 1, 0, 400, 100, 0, 0,   0,   0};
        tbl[12] = '{0, 1, 1, 0, 400, 100, 0, 0,   0,   0};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, tbl[i].t, tbl[i].a, tbl[i].h, tbl[i].ex, tbl[i].ey);
            chk($sformatf("tbl%0d_act", i), int'(bullet_active), tbl[i].e_act);
            chk($sformatf("tbl%0d_fire", i), int'(fire_pulse), tbl[i].e_fire);
            chk($sformatf("tbl%0d_x", i), int'(enBullet_X), tbl[i].e_x);
            chk($sformatf("tbl%0d_y", i), int'(enBullet_Y), tbl[i].e_y);
        end

        // Clamp onto the ship row, hold a full frame, then exit
        fire_at(300, 102);
        for (int i = 1; i <= 69; i++) step(0, 1, 1, 0, 300, 102);
        chk("pre_clamp_y", int'(enBullet_Y), 674);
        step(0, 1, 1, 0, 300, 102);
        chk("clamp_y", int'(enBullet_Y), Y_SHIP);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 300, 102);
        chk("clamp_hold_y", int'(enBullet_Y), Y_SHIP);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 300, 102);
        chk("last_y", int'(enBullet_Y), 760);
        chk("last_x", int'(enBullet_X), 300);
        step(0, 1, 1, 0, 300, 102);
        chk("exit_act", int'(bullet_active), 0);
        chk("exit_y", int'(enBullet_Y), 0);
        chk("exit_x", int'(enBullet_X), 0);

        // ship_hit coincident with a tick at Y=500, then held high
        fire_at(200, 480);
        step(0, 1, 1, 1, 200, 480);
        chk("hit_act", int'(bullet_active), 0);
        chk("hit_y", int'(enBullet_Y), 0);
        fires = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, i % 2, 1, 1, 200, 100);
            fires += int'(fire_pulse);
        end
        chk("hit_hold_fires", fires, 0);

        // enemy dies with one cooldown tick left
        step(1, 0, 0, 0, 0, 100);
        step(0, 0, 1, 0, 50, 100);
        step(0, 1, 1, 0, 50, 100);
        step(0, 1, 1, 0, 50, 100);
        step(0, 0, 0, 0, 50, 100);
        fires = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 0, 50, 100);
            fires += int'(fire_pulse);
        end
        chk("dead_wait_fires", fires, 0);

        // enemy dies mid-flight: bullet keeps falling to despawn
        fire_at(77, 600);
        k = 0;
        while (bullet_active && k < 40) begin
            step(0, 1, 0, 0, 77, 600);
            k++;
        end
        chk("dead_fly_ticks", k, 19);
        chk("dead_fly_act", int'(bullet_active), 0);

        // spawn below the screen: no fire, re-arm one cycle later
        step(1, 0, 0, 0, 10, 760);
        step(0, 0, 1, 0, 10, 760);
        fires = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 0, 10, 760);
            fires += int'(fire_pulse);
        end
        chk("offscreen_fires", fires, 0);
        chk("offscreen_act", int'(bullet_active), 0);
        step(0, 0, 1, 0, 10, 100);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 10, 100);
        chk("rearm_no_early", int'(fire_pulse), 0);
        step(0, 1, 1, 0, 10, 100);
        chk("rearm_fire", int'(fire_pulse), 1);

        // reset mid-flight at Y=300 with tick and hit present
        fire_at(999, 280);
        step(1, 1, 1, 1, 999, 280);
        chk("rst_fly_act", int'(bullet_active), 0);
        chk("rst_fly_x", int'(enBullet_X), 0);
        chk("rst_fly_y", int'(enBullet_Y), 0);
        chk("rst_fly_fire", int'(fire_pulse), 0);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 499) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 79) == 0,
                 int'($urandom_range(0, 2047)),
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(740, 2047))
                                             : int'($urandom_range(0, 760)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
